// File: rtl/mips16_pkg.sv
// Shared MIPS16 definitions: opcodes, multicycle FSM states and
// datapath select encodings used by both control decoders.
package mips16_pkg;

   localparam logic [2:0] OP_RTYPE = 3'b000;
   localparam logic [2:0] OP_LW    = 3'b001;
   localparam logic [2:0] OP_SW    = 3'b010;
   localparam logic [2:0] OP_J     = 3'b011;
   localparam logic [2:0] OP_ADDI  = 3'b100;

   typedef logic [3:0] state_t;

   localparam state_t S_IDLE   = 4'd0;
   localparam state_t S_FETCH  = 4'd1;
   localparam state_t S_DECODE = 4'd2;
   localparam state_t S_ADDR   = 4'd3;
   localparam state_t S_MEM_RD = 4'd4;
   localparam state_t S_MEM_WR = 4'd5;
   localparam state_t S_WB_MEM = 4'd6;
   localparam state_t S_EXEC_R = 4'd7;
   localparam state_t S_WB_R   = 4'd8;
   localparam state_t S_EXEC_I = 4'd9;
   localparam state_t S_WB_I   = 4'd10;
   localparam state_t S_JUMP   = 4'd11;

   localparam logic [1:0] ALUOP_FUNCT = 2'b00;
   localparam logic [1:0] ALUOP_ADD   = 2'b11;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_CONST2 = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;

   localparam logic [1:0] PCSRC_ALU  = 2'b00;
   localparam logic [1:0] PCSRC_JUMP = 2'b10;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic op_is_legal(input logic [2:0] op);
      return op inside {OP_RTYPE, OP_LW, OP_SW, OP_J, OP_ADDI};
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control-word decode for the multicycle controller;
// only the fetch and memory-write strobes look at mem_ready.
module mc_ctrl_decode
   import mips16_pkg::*;
(
   input  state_t     i_state,
   input  logic       i_mem_ready,
   input  logic [2:0] i_op,
   output ctrl_t      o_ctrl
);

   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.mem_read  = 1'b1;
            o_ctrl.alu_src_b = SRCB_CONST2;
            o_ctrl.pc_source = PCSRC_ALU;
            o_ctrl.ir_write  = i_mem_ready;
            o_ctrl.pc_write  = i_mem_ready;
         end
         S_DECODE: begin
            o_ctrl.illegal_op = ~op_is_legal(i_op);
         end
         S_ADDR, S_EXEC_I: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_IMM;
            o_ctrl.alu_op    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            o_ctrl.iord     = 1'b1;
            o_ctrl.mem_read = 1'b1;
         end
         S_MEM_WR: begin
            o_ctrl.iord       = 1'b1;
            o_ctrl.mem_write  = 1'b1;
            o_ctrl.instr_done = i_mem_ready;
         end
         S_WB_MEM: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.mem_to_reg = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_EXEC_R: begin
            o_ctrl.alu_src_a = 1'b1;
            o_ctrl.alu_src_b = SRCB_REG;
            o_ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_WB_R: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.reg_dst    = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_WB_I: begin
            o_ctrl.reg_write  = 1'b1;
            o_ctrl.instr_done = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pc_write   = 1'b1;
            o_ctrl.pc_source  = PCSRC_JUMP;
            o_ctrl.instr_done = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS16 control unit: state register, sequencing
// and retired-instruction counter around the control decode.
module multicycle_control
   import mips16_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [2:0]  op,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        ir_write,
   output logic        iord,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  alu_op,
   output logic [1:0]  pc_source,
   output logic        instr_done,
   output logic        illegal_op,
   output logic [15:0] instr_count
);

   state_t      r_state;
   state_t      w_next;
   ctrl_t       w_ctrl;
   logic [15:0] r_count;

   mc_ctrl_decode u_dec (
      .i_state     (r_state),
      .i_mem_ready (mem_ready),
      .i_op        (op),
      .o_ctrl      (w_ctrl)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = S_FETCH;
         S_FETCH:  if (mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_RTYPE:     w_next = S_EXEC_R;
               OP_LW, OP_SW: w_next = S_ADDR;
               OP_ADDI:      w_next = S_EXEC_I;
               OP_J:         w_next = S_JUMP;
               default:      w_next = S_FETCH;
            endcase
         end
         S_ADDR:   w_next = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
         S_MEM_RD: if (mem_ready) w_next = S_WB_MEM;
         S_MEM_WR: if (mem_ready) w_next = S_FETCH;
         S_EXEC_R: w_next = S_WB_R;
         S_EXEC_I: w_next = S_WB_I;
         S_WB_MEM, S_WB_R, S_WB_I, S_JUMP:
                   w_next = S_FETCH;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Counter wraps naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 r_count <= 16'd0;
      else if (w_ctrl.instr_done) r_count <= r_count + 16'd1;
   end

   assign pc_write    = w_ctrl.pc_write;
   assign ir_write    = w_ctrl.ir_write;
   assign iord        = w_ctrl.iord;
   assign mem_read    = w_ctrl.mem_read;
   assign mem_write   = w_ctrl.mem_write;
   assign mem_to_reg  = w_ctrl.mem_to_reg;
   assign reg_dst     = w_ctrl.reg_dst;
   assign reg_write   = w_ctrl.reg_write;
   assign alu_src_a   = w_ctrl.alu_src_a;
   assign alu_src_b   = w_ctrl.alu_src_b;
   assign alu_op      = w_ctrl.alu_op;
   assign pc_source   = w_ctrl.pc_source;
   assign instr_done  = w_ctrl.instr_done;
   assign illegal_op  = w_ctrl.illegal_op;
   assign instr_count = r_count;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed table, random
// instruction streams and reset / counter-wrap sequences.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  op = 3'd0;
   logic        mem_ready = 1'b0;
   logic        pc_write, ir_write, iord, mem_read, mem_write;
   logic        mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0]  alu_src_b, alu_op, pc_source;
   logic        instr_done, illegal_op;
   logic [15:0] instr_count;

   multicycle_control dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .op          (op),
      .mem_ready   (mem_ready),
      .pc_write    (pc_write),
      .ir_write    (ir_write),
      .iord        (iord),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_to_reg  (mem_to_reg),
      .reg_dst     (reg_dst),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .alu_op      (alu_op),
      .pc_source   (pc_source),
      .instr_done  (instr_done),
      .illegal_op  (illegal_op),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   typedef enum int {
      P_IDLE, P_FETCH, P_DECODE, P_ADDR, P_MEM_RD, P_MEM_WR,
      P_WB_MEM, P_EXEC_R, P_WB_R, P_EXEC_I, P_WB_I, P_JUMP
   } ph_e;

   typedef struct packed {
      logic       pc_write;
      logic       ir_write;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_source;
      logic       instr_done;
      logic       illegal_op;
   } out_t;

   typedef struct {
      ph_e  ph;
      logic mr;
   } cyc_t;

   typedef struct {
      logic [2:0] op;
      int         fw;
      int         mw;
      int         lat;
      int         dones;
   } vec_t;

   out_t        act;
   cyc_t        plan[$];
   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_count = 16'd0;

   assign act = {pc_write, ir_write, iord, mem_read, mem_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_source, instr_done, illegal_op};

   task automatic check_vec(input string name, input logic [31:0] got,
                            input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic logic rnd_bit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Control word each phase must present, straight from the rules
   function automatic out_t expect_out(ph_e ph, logic mr, logic [2:0] o);
      out_t e;
      e = '0;
      case (ph)
         P_FETCH: begin
            e.mem_read = 1'b1; e.alu_src_b = 2'b01;
            e.ir_write = mr;   e.pc_write  = mr;
         end
         P_DECODE: e.illegal_op = (o >= 3'd5);
         P_ADDR, P_EXEC_I: begin
            e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_op = 2'b11;
         end
         P_MEM_RD: begin e.iord = 1'b1; e.mem_read = 1'b1; end
         P_MEM_WR: begin
            e.iord = 1'b1; e.mem_write = 1'b1; e.instr_done = mr;
         end
         P_WB_MEM: begin
            e.reg_write = 1'b1; e.mem_to_reg = 1'b1; e.instr_done = 1'b1;
         end
         P_EXEC_R: e.alu_src_a = 1'b1;
         P_WB_R: begin
            e.reg_write = 1'b1; e.reg_dst = 1'b1; e.instr_done = 1'b1;
         end
         P_WB_I: begin e.reg_write = 1'b1; e.instr_done = 1'b1; end
         P_JUMP: begin
            e.pc_write = 1'b1; e.pc_source = 2'b10; e.instr_done = 1'b1;
         end
         default: e = '0;
      endcase
      return e;
   endfunction

   function automatic int base_lat(logic [2:0] o);
      case (o)
         3'd0:    return 4;
         3'd1:    return 5;
         3'd2:    return 4;
         3'd3:    return 3;
         3'd4:    return 4;
         default: return 2;
      endcase
   endfunction

   function automatic void build_plan(logic [2:0] o, int fw, int mw);
      plan.delete();
      repeat (fw) plan.push_back('{P_FETCH, 1'b0});
      plan.push_back('{P_FETCH, 1'b1});
      plan.push_back('{P_DECODE, rnd_bit()});
      case (o)
         3'd0: begin
            plan.push_back('{P_EXEC_R, rnd_bit()});
            plan.push_back('{P_WB_R, rnd_bit()});
         end
         3'd1: begin
            plan.push_back('{P_ADDR, rnd_bit()});
            repeat (mw) plan.push_back('{P_MEM_RD, 1'b0});
            plan.push_back('{P_MEM_RD, 1'b1});
            plan.push_back('{P_WB_MEM, rnd_bit()});
         end
         3'd2: begin
            plan.push_back('{P_ADDR, rnd_bit()});
            repeat (mw) plan.push_back('{P_MEM_WR, 1'b0});
            plan.push_back('{P_MEM_WR, 1'b1});
         end
         3'd3: plan.push_back('{P_JUMP, rnd_bit()});
         3'd4: begin
            plan.push_back('{P_EXEC_I, rnd_bit()});
            plan.push_back('{P_WB_I, rnd_bit()});
         end
         default: ;
      endcase
   endfunction

   // Entered and left at posedge+1 with the DUT expected in FETCH
   task automatic run_plan(input logic [2:0] o, output int lat,
                           output int dones);
      out_t e;
      lat = 0;
      dones = 0;
      foreach (plan[i]) begin
         if (plan[i].ph == P_DECODE || plan[i].ph == P_ADDR) op = o;
         else op = 3'($urandom_range(0, 7));
         mem_ready = plan[i].mr;
         #1;
         e = expect_out(plan[i].ph, plan[i].mr, o);
         check_vec($sformatf("%s_c%0d", plan[i].ph.name(), i + 1),
                   32'(act), 32'(e));
         check_vec("count", 32'(instr_count), 32'(m_count));
         if ((instr_done || illegal_op) && lat == 0) lat = i + 1;
         if (instr_done) dones++;
         if (e.instr_done) m_count = m_count + 16'd1;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic reset_release();
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      mem_ready = 1'b1;
      op = 3'($urandom_range(0, 7));
      #1;
      check_vec("idle_ctl", 32'(act), 32'd0);
      check_vec("idle_count", 32'(instr_count), 32'(m_count));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[$];
      int   lat, d;

      tbl.push_back('{3'd0, 0, 0, 4, 1});
      tbl.push_back('{3'd1, 0, 2, 7, 1});
      tbl.push_back('{3'd2, 0, 0, 4, 1});
      tbl.push_back('{3'd4, 0, 0, 4, 1});
      tbl.push_back('{3'd3, 0, 0, 3, 1});
      tbl.push_back('{3'd7, 0, 0, 2, 0});
      tbl.push_back('{3'd1, 1, 0, 6, 1});
      tbl.push_back('{3'd2, 2, 1, 7, 1});
      tbl.push_back('{3'd5, 1, 0, 3, 0});
      tbl.push_back('{3'd6, 0, 0, 2, 0});
      tbl.push_back('{3'd1, 0, 0, 5, 1});

      repeat (2) @(posedge clk);
      #1;
      mem_ready = 1'b1;
      #1;
      check_vec("rst_ctl", 32'(act), 32'd0);
      check_vec("rst_count", 32'(instr_count), 32'd0);
      reset_release();

      foreach (tbl[i]) begin
         build_plan(tbl[i].op, tbl[i].fw, tbl[i].mw);
         run_plan(tbl[i].op, lat, d);
         check_vec($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
         check_vec($sformatf("tbl%0d_done", i), 32'(d), 32'(tbl[i].dones));
      end

      for (int k = 0; k < 40; k++) begin
         logic [2:0] o;
         int         fw, mw, el;
         o  = 3'($urandom_range(0, 7));
         fw = $urandom_range(0, 2);
         mw = $urandom_range(0, 3);
         build_plan(o, fw, mw);
         run_plan(o, lat, d);
         el = base_lat(o) + fw + ((o == 3'd1 || o == 3'd2) ? mw : 0);
         check_vec("rnd_lat", 32'(lat), 32'(el));
         check_vec("rnd_done", 32'(d), (o <= 3'd4) ? 32'd1 : 32'd0);
      end

      // Reset while a store is stalled on memory
      plan.delete();
      plan.push_back('{P_FETCH, 1'b1});
      plan.push_back('{P_DECODE, 1'b0});
      plan.push_back('{P_ADDR, 1'b0});
      plan.push_back('{P_MEM_WR, 1'b0});
      plan.push_back('{P_MEM_WR, 1'b0});
      run_plan(3'd2, lat, d);
      mem_ready = 1'b0;
      op = 3'd2;
      #1;
      rst_n = 1'b0;
      #1;
      check_vec("rstwr_ctl", 32'(act), 32'd0);
      check_vec("rstwr_count", 32'(instr_count), 32'd0);
      m_count = 16'd0;
      reset_release();

      build_plan(3'd0, 0, 0);
      run_plan(3'd0, lat, d);
      check_vec("post_rst_lat", 32'(lat), 32'd4);

      // Counter wrap on a jump retire
      force dut.r_count = 16'hFFFF;
      #1;
      release dut.r_count;
      m_count = 16'hFFFF;
      build_plan(3'd3, 0, 0);
      run_plan(3'd3, lat, d);
      check_vec("wrap_count", 32'(instr_count), 32'd0);
      check_vec("wrap_done", 32'(d), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on its rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: op  in  3  opcode from the instruction register, valid from the DECODE state onward.
REQ-004 SHALL have ports: mem_ready  in  1  memory completion strobe for the current read or write.
REQ-005 SHALL have the following 1-bit outputs:
- pc_write, ir_write, iord, mem_read, mem_write, mem_to_reg, reg_dst, reg_write, alu_src_a.
REQ-006 SHALL have the following 2-bit outputs:
- alu_src_b: 00 reg, 01 const 2, 10 sign-ext imm.
- alu_op: 00 funct-decoded, 11 add.
- pc_source: 00 ALU result, 10 jump target.
REQ-007 SHALL have ports: instr_done  out  1  one-cycle pulse on instruction retire; illegal_op  out  1  one-cycle pulse on unknown opcode; instr_count  out  16  retired-instruction counter.

Function
REQ-008 SHALL implement a Moore FSM with states:
- IDLE, FETCH, DECODE, ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC_R, WB_R, EXEC_I, WB_I, JUMP.
- Control outputs are a pure decode of the state, except the gated strobes in REQ-009.
REQ-009 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, pc_source=00.
- ir_write and pc_write assert only in a cycle where mem_ready=1.
- Stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
REQ-010 DECODE SHALL branch on op:
- 000 to EXEC_R; 001 or 010 to ADDR; 100 to EXEC_I; 011 to JUMP.
- 101, 110, 111 to FETCH with illegal_op=1 for that cycle; no retire.
REQ-011 ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=11, then go to MEM_RD if op=001, else MEM_WR.
REQ-012 MEM_RD SHALL drive iord=1, mem_read=1, hold until mem_ready=1, then go to WB_MEM.
REQ-013 WB_MEM SHALL drive reg_write=1, mem_to_reg=1, reg_dst=0, then go to FETCH.
REQ-014 MEM_WR SHALL drive iord=1, mem_write=1, hold until mem_ready=1, then go to FETCH.
REQ-015 EXEC_R SHALL drive alu_src_a=1, alu_src_b=00, alu_op=00, then go to WB_R.
- WB_R SHALL drive reg_write=1, reg_dst=1, then go to FETCH.
REQ-016 EXEC_I SHALL drive alu_src_a=1, alu_src_b=10, alu_op=11, then go to WB_I.
- WB_I SHALL drive reg_write=1, reg_dst=0, then go to FETCH.
REQ-017 JUMP SHALL drive pc_write=1, pc_source=10, then go to FETCH.
REQ-018 All outputs not listed for a state SHALL be 0 in that state; mem_read and mem_write SHALL never both be 1.
REQ-019 instr_done SHALL pulse on the last cycle of WB_MEM, WB_R, WB_I, JUMP, and of MEM_WR when mem_ready=1.
- instr_count increments on each instr_done and wraps FFFF to 0000.
REQ-020 Zero-wait latency in cycles, FETCH to retire:
- R-type 4, lw 5, sw 4, addi 4, j 3.
- Each mem_ready=0 cycle adds 1.
REQ-021 op SHALL be ignored outside DECODE and ADDR.
- A mem_ready pulse outside FETCH, MEM_RD or MEM_WR is ignored.

Reset
REQ-022 rst_n=0 SHALL immediately force state to IDLE, instr_count to 0, and all outputs to 0, regardless of the current state (including mid-wait in MEM_RD or MEM_WR).
REQ-023 IDLE SHALL go to FETCH on the first clk edge after rst_n is released; IDLE drives all outputs 0.

Structure
REQ-024 Opcode constants, the state enumeration and the alu_op/alu_src_b/pc_source encodings SHALL live in shared package mips16_pkg; the single-cycle control decoder uses the same opcode constants.
REQ-025 The state-to-control-word decode SHALL be one sub-module, mc_ctrl_decode (combinational).
- The state register, next-state logic and counter stay in multicycle_control.

Verification
REQ-026 Reset, then op=000 with mem_ready held at 1 -> states FETCH, DECODE, EXEC_R, WB_R; reg_dst=1, reg_write=1 in cycle 4; instr_count=0001.
REQ-027 op=001 with mem_ready=0 for 2 cycles in MEM_RD -> WB_MEM reached on cycle 7; mem_to_reg=1, reg_write=1; one instr_done pulse.
REQ-028 op=010, mem_ready=1 -> mem_write=1 and iord=1 in cycle 4; reg_write stays 0 throughout; instr_done in cycle 4.
REQ-029 op=111 -> illegal_op pulses in DECODE; next state FETCH; instr_count unchanged.
REQ-030 rst_n low while in MEM_WR with mem_ready=0 -> outputs 0 and state IDLE before the next edge; instr_count=0000.
REQ-031 Preload 65535 retires with op=011 -> next instr_done wraps instr_count to 0000; pc_source=10 and pc_write=1 in JUMP.
